key_buffer_ctrl: RTL and testbench

KEY_BUFFER_CTRL -- requirements
Module: key_buffer_ctrl

---
 rtl/vo_pkg.sv | 14 +
 rtl/key_buffer_ctrl_if.sv | 31 +++
 rtl/key_occ_counter.sv | 31 +++
 rtl/key_buffer_ctrl.sv | 138 +++++++++++++
 tb/tb_key_buffer_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vo_pkg.sv
// Shared types and defaults for the visual-odometry keypoint path.
// Holds the keypoint buffer FSM state type and default buffer sizing.
package vo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } kb_state_e;

    localparam int KB_SIZE  = 100;
    localparam int KB_CNT_W = 10;

endpackage

// File: rtl/key_buffer_ctrl_if.sv
// Keypoint buffer handshake bundle: detector/matcher handshakes,
// buffer strobes and occupancy. master = controller, slave = counter.
interface key_buffer_ctrl_if #(
    parameter int CNT_W = 10
);

    logic             kp_valid;
    logic             kp_ready;
    logic             pop_valid;
    logic             pop_ready;
    logic             flag;
    logic             hit;
    logic [CNT_W-1:0] count;

    modport master (
        input  kp_valid,
        input  pop_ready,
        input  count,
        output kp_ready,
        output pop_valid,
        output flag,
        output hit
    );

    modport slave (
        input  flag,
        input  hit,
        output count
    );

endinterface

// File: rtl/key_occ_counter.sv
// Keypoint buffer occupancy counter: count + push - pop,
// held inside [0, SIZE] even if the strobes misbehave.
module key_occ_counter
    import vo_pkg::*;
#(
    parameter int SIZE  = KB_SIZE,
    parameter int CNT_W = KB_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    key_buffer_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(SIZE);

    logic [CNT_W-1:0] count_q;

    // Up on insert only, down on consume only, hold on both or neither.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (bus.flag && !bus.hit && count_q < FULL) begin
            count_q <= count_q + 1'b1;
        end else if (bus.hit && !bus.flag && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign bus.count = count_q;

endmodule

// File: rtl/key_buffer_ctrl.sv
// Keypoint buffer controller: IDLE/FILL/DRAIN frame FSM, push/pop strobes.
// Define KEY_BUF_CTRL_DROP_CNT_EN to build the per-frame drop counter.
module key_buffer_ctrl
    import vo_pkg::*;
#(
    parameter int SIZE  = KB_SIZE,
    parameter int CNT_W = KB_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_frame_start,
    input  logic             i_frame_end,
    input  logic             i_kp_valid,
    output logic             o_kp_ready,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic             o_flag,
    output logic             o_hit,
    output logic [CNT_W-1:0] o_count,
    output logic [1:0]       o_state,
    output logic [15:0]      o_drop_cnt
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(SIZE);

    key_buffer_ctrl_if #(.CNT_W(CNT_W)) bus ();

    kb_state_e state_q;
    kb_state_e state_d;
    logic      pending_q;
    logic      full;
    logic      empty;
    logic      accept;
    logic      push;
    logic      pop;
    logic      start_fill;

    assign bus.kp_valid  = i_kp_valid;
    assign bus.pop_ready = i_pop_ready;

    assign full  = (bus.count >= FULL);
    assign empty = (bus.count == '0);

    // Handshakes are gated by reset so an abandoned frame emits no strobes.
    assign bus.kp_ready  = i_rst_n && (state_q == ST_FILL);
    assign bus.pop_valid = i_rst_n && !empty &&
                           (state_q == ST_FILL || state_q == ST_DRAIN);

    assign accept = bus.kp_valid && bus.kp_ready;
    assign pop    = bus.pop_valid && bus.pop_ready;
    assign push   = accept && (!full || pop);

    assign bus.flag = push;
    assign bus.hit  = pop;

    key_occ_counter #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) u_occ (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    // Frame sequencing; a start seen while draining resumes FILL when empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (i_frame_end) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_d = (pending_q || i_frame_start) ? ST_FILL : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember a frame start that arrives before the drain has finished.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending_q <= 1'b0;
        end else if (state_q != ST_DRAIN || state_d != ST_DRAIN) begin
            pending_q <= 1'b0;
        end else if (i_frame_start) begin
            pending_q <= 1'b1;
        end
    end

    assign start_fill = (state_d == ST_FILL) && (state_q != ST_FILL);

`ifdef KEY_BUF_CTRL_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_q;

    assign drop = accept && full && !pop;

    // Per-frame drop tally, cleared on frame entry, saturating.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            drop_q <= '0;
        end else if (start_fill) begin
            drop_q <= '0;
        end else if (drop && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign o_drop_cnt = drop_q;
`else
    logic unused_start_fill;

    assign unused_start_fill = start_fill;
    assign o_drop_cnt        = '0;
`endif

    assign o_kp_ready  = bus.kp_ready;
    assign o_pop_valid = bus.pop_valid;
    assign o_flag      = bus.flag;
    assign o_hit       = bus.hit;
    assign o_count     = bus.count;
    assign o_state     = state_q;

endmodule

// File: tb/tb_key_buffer_ctrl.sv
// Directed self-checking bench for key_buffer_ctrl (SIZE=4).
// Drop expectations follow KEY_BUF_CTRL_DROP_CNT_EN.
module tb_key_buffer_ctrl;

    localparam int SIZE  = 4;
    localparam int CNT_W = 10;

`ifdef KEY_BUF_CTRL_DROP_CNT_EN
    localparam int DROP_ON = 1;
`else
    localparam int DROP_ON = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             frame_start;
    logic             frame_end;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic [15:0]      drop_cnt;

    int n_chk;
    int n_fail;

    key_buffer_ctrl_if #(.CNT_W(CNT_W)) bus ();

    key_buffer_ctrl #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_start (frame_start),
        .i_frame_end   (frame_end),
        .i_kp_valid    (bus.kp_valid),
        .o_kp_ready    (bus.kp_ready),
        .o_pop_valid   (bus.pop_valid),
        .i_pop_ready   (bus.pop_ready),
        .o_flag        (bus.flag),
        .o_hit         (bus.hit),
        .o_count       (count),
        .o_state       (state),
        .o_drop_cnt    (drop_cnt)
    );

    assign bus.count = count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n        = 1'b0;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        bus.kp_valid = 1'b0;
        bus.pop_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (count !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        n_chk++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state got %0d want 0", state);
        end
        n_chk++;
        if ({bus.kp_ready, bus.pop_valid, bus.flag, bus.hit} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outs got %b want 0000",
                     {bus.kp_ready, bus.pop_valid, bus.flag, bus.hit});
        end
        n_chk++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_drop got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_fill;
        int flags;
        flags = 0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.kp_valid = 1'b1;
            #1;
            if (bus.flag === 1'b1) flags++;
            @(negedge clk);
        end
        bus.kp_valid = 1'b0;
        #1;
        n_chk++;
        if (flags !== 3) begin
            n_fail++;
            $display("FAIL fill_flags got %0d want 3", flags);
        end
        n_chk++;
        if (count !== 10'd3) begin
            n_fail++;
            $display("FAIL fill_count got %0d want 3", count);
        end
        n_chk++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL fill_state got %0d want 1", state);
        end
        n_chk++;
        if (bus.pop_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_pop_valid got %b want 1", bus.pop_valid);
        end
    endtask

    task automatic test_drop;
        int flags;
        flags = 0;
        bus.kp_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            if (bus.flag === 1'b1) flags++;
            @(negedge clk);
        end
        bus.kp_valid = 1'b0;
        #1;
        n_chk++;
        if (flags !== 0) begin
            n_fail++;
            $display("FAIL drop_flags got %0d want 0", flags);
        end
        n_chk++;
        if (count !== 10'd4) begin
            n_fail++;
            $display("FAIL drop_count got %0d want 4", count);
        end
        n_chk++;
        if (drop_cnt !== 16'(2 * DROP_ON)) begin
            n_fail++;
            $display("FAIL drop_cnt got %0d want %0d", drop_cnt, 2 * DROP_ON);
        end
    endtask

    task automatic test_full_push_pop;
        bus.kp_valid  = 1'b1;
        bus.pop_ready = 1'b1;
        #1;
        n_chk++;
        if ({bus.flag, bus.hit} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_pp_strobes got %b want 11", {bus.flag, bus.hit});
        end
        @(negedge clk);
        bus.kp_valid  = 1'b0;
        bus.pop_ready = 1'b0;
        #1;
        n_chk++;
        if (count !== 10'd4) begin
            n_fail++;
            $display("FAIL full_pp_count got %0d want 4", count);
        end
        n_chk++;
        if (drop_cnt !== 16'(2 * DROP_ON)) begin
            n_fail++;
            $display("FAIL full_pp_drop got %0d want %0d", drop_cnt, 2 * DROP_ON);
        end
    endtask

    task automatic test_drain;
        int hits;
        hits = 0;
        bus.pop_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.pop_ready = 1'b0;
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        #1;
        n_chk++;
        if (state !== 2'd2 || count !== 10'd2) begin
            n_fail++;
            $display("FAIL drain_enter got state %0d count %0d want 2 2", state, count);
        end
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.hit === 1'b1) hits++;
            @(negedge clk);
        end
        n_chk++;
        if (hits !== 2) begin
            n_fail++;
            $display("FAIL drain_hits got %0d want 2", hits);
        end
        #1;
        n_chk++;
        if (state !== 2'd0 || bus.pop_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_exit got state %0d pop_valid %b want 0 0",
                     state, bus.pop_valid);
        end
        bus.pop_ready = 1'b0;
    endtask

    task automatic test_pending;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        bus.kp_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.kp_valid = 1'b0;
        #1;
        n_chk++;
        if (count !== 10'd4 || drop_cnt !== 16'(DROP_ON)) begin
            n_fail++;
            $display("FAIL pend_setup got count %0d drop %0d want 4 %0d",
                     count, drop_cnt, DROP_ON);
        end
        bus.pop_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.pop_ready = 1'b0;
        frame_end = 1'b1;
        @(negedge clk);
        frame_end   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        n_chk++;
        if (state !== 2'd2 || count !== 10'd1) begin
            n_fail++;
            $display("FAIL pend_hold got state %0d count %0d want 2 1", state, count);
        end
        bus.pop_ready = 1'b1;
        #1;
        n_chk++;
        if (bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_last_hit got %b want 1", bus.hit);
        end
        @(negedge clk);
        bus.pop_ready = 1'b0;
        #1;
        n_chk++;
        if (state !== 2'd2 || count !== 10'd0) begin
            n_fail++;
            $display("FAIL pend_empty got state %0d count %0d want 2 0", state, count);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (state !== 2'd1 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL pend_refill got state %0d drop %0d want 1 0", state, drop_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bus.kp_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.kp_valid = 1'b0;
        #1;
        n_chk++;
        if (count !== 10'd3 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL rmid_setup got count %0d state %0d want 3 1", count, state);
        end
        rst_n = 1'b0;
        bus.pop_ready = 1'b1;
        #1;
        n_chk++;
        if (bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_hit_in_reset got %b want 0", bus.hit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (count !== 10'd0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL rmid_after got count %0d state %0d want 0 0", count, state);
        end
        n_chk++;
        if (bus.hit !== 1'b0 || bus.pop_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_strobes got hit %b pop_valid %b want 0 0",
                     bus.hit, bus.pop_valid);
        end
        bus.pop_ready = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_fill();
        test_drop();
        test_full_push_pop();
        test_drain();
        test_pending();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
